mastermind_game: RTL and testbench
==================================

// Module: mastermind_game
// PURPOSE
//  Two-player Mastermind controller. Players alternate as code maker and code breaker
//  over 3-bit switches (SW) and per-player enter buttons. The block holds the secret,
//  scores guesses, tracks breaker lives, scores and rounds, and drives status and feedback LEDs.
//  Top-level game FSM of the board design.
// PARAMETERS
//  LIVES      3  guesses per breaker per round
//  ANIM_CYC   4  clocks of life-animation / feedback display
//  END_CYC    8  clocks of round-result display before the next round
//  WIN_SCORE  2  score that ends the match
// PORTS
//  clk               in   1   system clock, rising edge
//  reset             in   1   asynchronous, active-low reset
//  enterA            in   1   player A enter button, level; rising edge = one press
//  enterB            in   1   player B enter button, level; rising edge = one press
//  SW                in   3   letter code; 3'b000 invalid, 001..111 valid
//  round_count_disp  out  2   completed rounds, saturates at 3
//  scoreA_disp       out  2   player A score, saturates at 3
//  scoreB_disp       out  2   player B score, saturates at 3
//  leds_debug        out  12  secret {L1,L2,L3,L4}; L1 in [11:9]
//  led_feedback      out  8   guess feedback, lives or winner pattern
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; all outputs 0; lives=LIVES; letter index=0; edge detectors cleared.
//  - Press = registered rising edge of enterX: 1 clock high input = exactly 1 press. A press by the
//    player not owning the current phase is ignored. Presses during ANIM/FEEDBACK/END are ignored.
//  - IDLE: the first press selects the first maker (A or B); SW ignored; A wins a same-cycle tie.
//    Next state MAKER.
//  - MAKER: each maker press with SW!=0 stores SW in the next slot (L1..L4) and leds_debug updates
//    next clock. SW=0 press is ignored. leds_debug is cleared on MAKER entry.
//    After the 4th letter: lives=LIVES, go to ANIM.
//  - ANIM (ANIM_CYC clocks): led_feedback = thermometer of lives in [2:0]
//    (3 -> 8'b0000_0111); then BREAKER.
//  - BREAKER: breaker presses with SW!=0 fill guess G1..G4. On the 4th, compute feedback and go to FEEDBACK.
//  - Feedback: per position i (i=0 is L1, in bits [7:6]):
//      11 = exact match
//      01 = letter present at another unmatched secret slot
//      00 = otherwise
//    Count each secret letter once; exact matches take priority.
//  - FEEDBACK (ANIM_CYC clocks) holds led_feedback, then:
//      all exact            -> breaker score+1, go to END
//      else lives-1, lives=0 -> maker score+1, go to END
//      else                 -> ANIM (guess retry; guess buffer cleared)
//  - END (END_CYC clocks): round_count+1 (saturating). If either score >= WIN_SCORE, go to FINISH.
//    Otherwise swap roles and go to MAKER.
//  - FINISH: led_feedback = 8'hF0 (A wins) or 8'h0F (B wins); all presses ignored until reset.
//  - Scores and round count change only in the FEEDBACK->END transition and on END entry;
//    they are never reset mid-game except by reset.
//  - Reset asserted in any state returns to IDLE immediately; there is no partial-state retention.
// TESTING
//  1. Reset, then enterA pulse -> MAKER with A maker; all displays 0.
//  2. A enters 100,001,010,011 -> leds_debug = 12'h853.
//     B guesses the same -> led_feedback = 8'hFF, scoreB=1, round=1, then MAKER with B maker.
//  3. B enters 111 x4 (leds_debug = 12'hFFF); A guesses 001 x4 three times
//     -> led_feedback = 0 each time, lives 3->2->1->0, scoreB=2, round=2, FINISH, led_feedback = 8'h0F.
//  4. Secret 001,010,011,100; guess 010,001,011,111 -> led_feedback = 8'b01_01_11_00; lives 3->2.
//  5. SW=000 pressed by maker, enterB pressed during A's maker phase
//     -> both ignored, letter index unchanged.
//  6. Reset pulsed mid-BREAKER -> all outputs 0, state IDLE, next press starts a fresh game.

Source files
------------

// File: rtl/mastermind_game_if.sv
// Player-facing signals of the Mastermind controller: enter buttons, letter switches, and displays.
interface mastermind_game_if;
  logic        enterA;
  logic        enterB;
  logic [2:0]  SW;
  logic [1:0]  round_count_disp;
  logic [1:0]  scoreA_disp;
  logic [1:0]  scoreB_disp;
  logic [11:0] leds_debug;
  logic [7:0]  led_feedback;

  modport slave (
    input  enterA, enterB, SW,
    output round_count_disp, scoreA_disp, scoreB_disp, leds_debug, led_feedback
  );

  modport master (
    output enterA, enterB, SW,
    input  round_count_disp, scoreA_disp, scoreB_disp, leds_debug, led_feedback
  );
endinterface

// File: rtl/mastermind_game.sv
// Two-player Mastermind game FSM: holds the secret, scores guesses, tracks lives, scores and rounds.
// A press takes effect on the clock edge where it is seen; presses in timed display states are dropped.
module mastermind_game #(
  parameter int LIVES     = 3,
  parameter int ANIM_CYC  = 4,
  parameter int END_CYC   = 8,
  parameter int WIN_SCORE = 2
) (
  input  logic             clk,
  input  logic             reset,
  mastermind_game_if.slave io
);
  localparam int LW = $clog2(LIVES + 1);
  localparam int CW = $clog2((END_CYC > ANIM_CYC) ? END_CYC : ANIM_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_MAKER, S_ANIM, S_BREAKER, S_FEEDBACK, S_END, S_FINISH
  } state_t;

  state_t           state_q, state_d;
  logic             ena_prev_q, enb_prev_q;
  logic             maker_b_q, maker_b_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][2:0]  secret_q, secret_d;
  logic [2:0][2:0]  guess_q, guess_d;
  logic [LW-1:0]    lives_q, lives_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       fb_q, fb_d;
  logic [1:0]       score_a_q, score_a_d;
  logic [1:0]       score_b_q, score_b_d;
  logic [1:0]       round_q, round_d;

  logic             press_a, press_b, maker_press, breaker_press, sw_ok;
  logic [3:0][2:0]  guess_full;
  logic [3:0]       exact, used;
  logic             found;
  logic [7:0]       fb_calc, therm;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  assign press_a       = io.enterA & ~ena_prev_q;
  assign press_b       = io.enterB & ~enb_prev_q;
  assign maker_press   = maker_b_q ? press_b : press_a;
  assign breaker_press = maker_b_q ? press_a : press_b;
  assign sw_ok         = (io.SW != 3'b000);

  // The 4th letter is scored straight from SW so feedback is ready on the same edge.
  always_comb begin
    guess_full = {io.SW, guess_q};
    fb_calc    = '0;
    found      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exact[i] = (guess_full[i] == secret_q[i]);
    end
    used = exact;
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      if (exact[i]) begin
        fb_calc[7-2*i -: 2] = 2'b11;
      end else begin
        for (int j = 0; j < 4; j++) begin
          if (!found && !used[j] && (secret_q[j] == guess_full[i])) begin
            used[j] = 1'b1;
            found   = 1'b1;
          end
        end
        if (found) fb_calc[7-2*i -: 2] = 2'b01;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    maker_b_d = maker_b_q;
    idx_d     = idx_q;
    secret_d  = secret_q;
    guess_d   = guess_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    fb_d      = fb_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    round_d   = round_q;
    case (state_q)
      S_IDLE: begin
        if (press_a || press_b) begin
          maker_b_d = ~press_a;
          idx_d     = 2'd0;
          secret_d  = '0;
          state_d   = S_MAKER;
        end
      end
      S_MAKER: begin
        if (maker_press && sw_ok) begin
          secret_d[idx_q] = io.SW;
          idx_d           = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            lives_d = LW'(LIVES);
            guess_d = '0;
            cnt_d   = '0;
            state_d = S_ANIM;
          end
        end
      end
      S_ANIM: begin
        if (cnt_q == CW'(ANIM_CYC - 1)) begin
          cnt_d   = '0;
          idx_d   = 2'd0;
          state_d = S_BREAKER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAKER: begin
        if (breaker_press && sw_ok) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            fb_d    = fb_calc;
            cnt_d   = '0;
            state_d = S_FEEDBACK;
          end else begin
            guess_d[idx_q] = io.SW;
          end
        end
      end
      S_FEEDBACK: begin
        if (cnt_q == CW'(ANIM_CYC - 1)) begin
          cnt_d = '0;
          if (fb_q == 8'hFF) begin
            if (maker_b_q) score_a_d = sat_inc(score_a_q);
            else           score_b_d = sat_inc(score_b_q);
            round_d = sat_inc(round_q);
            state_d = S_END;
          end else if (lives_q == LW'(1)) begin
            lives_d = '0;
            if (maker_b_q) score_b_d = sat_inc(score_b_q);
            else           score_a_d = sat_inc(score_a_q);
            round_d = sat_inc(round_q);
            state_d = S_END;
          end else begin
            lives_d = lives_q - LW'(1);
            guess_d = '0;
            idx_d   = 2'd0;
            state_d = S_ANIM;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_END: begin
        if (cnt_q == CW'(END_CYC - 1)) begin
          cnt_d = '0;
          if ((score_a_q >= 2'(WIN_SCORE)) || (score_b_q >= 2'(WIN_SCORE))) begin
            state_d = S_FINISH;
          end else begin
            maker_b_d = ~maker_b_q;
            secret_d  = '0;
            idx_d     = 2'd0;
            state_d   = S_MAKER;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FINISH: begin
        state_d = S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ena_prev_q <= 1'b0;
      enb_prev_q <= 1'b0;
      maker_b_q  <= 1'b0;
      idx_q      <= 2'd0;
      secret_q   <= '0;
      guess_q    <= '0;
      lives_q    <= LW'(LIVES);
      cnt_q      <= '0;
      fb_q       <= '0;
      score_a_q  <= 2'd0;
      score_b_q  <= 2'd0;
      round_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      ena_prev_q <= io.enterA;
      enb_prev_q <= io.enterB;
      maker_b_q  <= maker_b_d;
      idx_q      <= idx_d;
      secret_q   <= secret_d;
      guess_q    <= guess_d;
      lives_q    <= lives_d;
      cnt_q      <= cnt_d;
      fb_q       <= fb_d;
      score_a_q  <= score_a_d;
      score_b_q  <= score_b_d;
      round_q    <= round_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      therm[i] = (i < int'(lives_q));
    end
  end

  always_comb begin
    io.led_feedback = 8'h00;
    case (state_q)
      S_ANIM:     io.led_feedback = therm;
      S_FEEDBACK: io.led_feedback = fb_q;
      S_FINISH:   io.led_feedback = (score_a_q >= 2'(WIN_SCORE)) ? 8'hF0 : 8'h0F;
      default:    io.led_feedback = 8'h00;
    endcase
  end

  assign io.leds_debug       = {secret_q[0], secret_q[1], secret_q[2], secret_q[3]};
  assign io.scoreA_disp      = score_a_q;
  assign io.scoreB_disp      = score_b_q;
  assign io.round_count_disp = round_q;
endmodule

// File: tb/tb_mastermind_game.sv
// Scenario bench for mastermind_game; feedback expectations flow through a scoreboard queue.
module tb_mastermind_game;
  logic clk = 1'b0;
  logic rst_n;
  mastermind_game_if ifc();

  mastermind_game #(.LIVES(3), .ANIM_CYC(4), .END_CYC(8), .WIN_SCORE(2)) dut (
    .clk   (clk),
    .reset (rst_n),
    .io    (ifc)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_fb_q[$];
  logic [7:0] exp_fb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0][2:0] mk(input logic [2:0] a, b, c, d);
    logic [3:0][2:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Letter-count model: non-exact secret letters form a pool consumed left to right.
  function automatic logic [7:0] model_fb(input logic [3:0][2:0] s, input logic [3:0][2:0] g);
    int         pool[8];
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) pool[k] = 0;
    for (int i = 0; i < 4; i++) if (s[i] != g[i]) pool[s[i]]++;
    for (int i = 0; i < 4; i++) begin
      if (s[i] == g[i]) r[7-2*i -: 2] = 2'b11;
      else if (pool[g[i]] > 0) begin
        r[7-2*i -: 2] = 2'b01;
        pool[g[i]]--;
      end
    end
    return r;
  endfunction

  task automatic press(input bit by_b, input logic [2:0] sw);
    @(negedge clk);
    ifc.SW = sw;
    if (by_b) ifc.enterB = 1'b1; else ifc.enterA = 1'b1;
    @(negedge clk);
    ifc.enterA = 1'b0;
    ifc.enterB = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter_code(input bit by_b, input logic [3:0][2:0] c);
    for (int k = 0; k < 4; k++) press(by_b, c[k]);
  endtask

  task automatic guess(input bit by_b, input logic [3:0][2:0] g, input logic [7:0] exp);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_fb_q.push_back(exp);
      press(by_b, g[k]);
    end
  endtask

  task automatic test_reset;
    ifc.enterA = 1'b0; ifc.enterB = 1'b0; ifc.SW = 3'd0;
    rst_n = 1'b0;
    idle(3);
    n_vec++; if (ifc.leds_debug !== 12'h000) begin n_err++; $display("FAIL reset_leds_debug got %h exp 000", ifc.leds_debug); end
    n_vec++; if (ifc.led_feedback !== 8'h00) begin n_err++; $display("FAIL reset_led_feedback got %h exp 00", ifc.led_feedback); end
    n_vec++; if ({ifc.round_count_disp, ifc.scoreA_disp, ifc.scoreB_disp} !== 6'd0) begin
      n_err++; $display("FAIL reset_counters got r%0d a%0d b%0d exp 0 0 0", ifc.round_count_disp, ifc.scoreA_disp, ifc.scoreB_disp);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_round_b_wins;
    press(1'b0, 3'd5);
    n_vec++; if ({ifc.round_count_disp, ifc.scoreA_disp, ifc.scoreB_disp, ifc.leds_debug, ifc.led_feedback} !== 26'd0) begin
      n_err++; $display("FAIL idle_press_displays got %h %h exp all zero", ifc.leds_debug, ifc.led_feedback);
    end
    enter_code(1'b0, mk(3'd4, 3'd1, 3'd2, 3'd3));
    n_vec++; if (ifc.leds_debug !== 12'h853) begin n_err++; $display("FAIL secret_853 got %h exp 853", ifc.leds_debug); end
    n_vec++; if (ifc.led_feedback !== 8'h07) begin n_err++; $display("FAIL anim_lives3 got %h exp 07", ifc.led_feedback); end
    idle(4);
    guess(1'b1, mk(3'd4, 3'd1, 3'd2, 3'd3), 8'hFF);
    exp_fb = exp_fb_q.pop_front();
    n_vec++; if (ifc.led_feedback !== exp_fb) begin n_err++; $display("FAIL fb_all_exact got %h exp %h", ifc.led_feedback, exp_fb); end
    idle(4);
    n_vec++; if (ifc.scoreB_disp !== 2'd1 || ifc.scoreA_disp !== 2'd0) begin
      n_err++; $display("FAIL score_after_win got a%0d b%0d exp a0 b1", ifc.scoreA_disp, ifc.scoreB_disp);
    end
    n_vec++; if (ifc.round_count_disp !== 2'd1) begin n_err++; $display("FAIL round_after_win got %0d exp 1", ifc.round_count_disp); end
    idle(8);
    n_vec++; if (ifc.leds_debug !== 12'h000) begin n_err++; $display("FAIL maker_entry_clear got %h exp 000", ifc.leds_debug); end
  endtask

  task automatic test_b_maker_to_finish;
    logic [7:0] th;
    press(1'b0, 3'd1);
    press(1'b1, 3'd0);
    n_vec++; if (ifc.leds_debug !== 12'h000) begin n_err++; $display("FAIL ignored_presses got %h exp 000", ifc.leds_debug); end
    press(1'b1, 3'd7);
    n_vec++; if (ifc.leds_debug !== 12'hE00) begin n_err++; $display("FAIL first_slot got %h exp E00", ifc.leds_debug); end
    for (int k = 0; k < 3; k++) press(1'b1, 3'd7);
    n_vec++; if (ifc.leds_debug !== 12'hFFF) begin n_err++; $display("FAIL secret_FFF got %h exp FFF", ifc.leds_debug); end
    for (int r = 0; r < 3; r++) begin
      idle(4);
      guess(1'b0, mk(3'd1, 3'd1, 3'd1, 3'd1), model_fb(mk(3'd7, 3'd7, 3'd7, 3'd7), mk(3'd1, 3'd1, 3'd1, 3'd1)));
      exp_fb = exp_fb_q.pop_front();
      n_vec++; if (ifc.led_feedback !== exp_fb) begin n_err++; $display("FAIL fb_miss_%0d got %h exp %h", r, ifc.led_feedback, exp_fb); end
      idle(4);
      if (r < 2) begin
        th = 8'((1 << (2 - r)) - 1);
        n_vec++; if (ifc.led_feedback !== th) begin n_err++; $display("FAIL lives_anim_%0d got %h exp %h", r, ifc.led_feedback, th); end
      end else begin
        n_vec++; if (ifc.scoreB_disp !== 2'd2 || ifc.scoreA_disp !== 2'd0 || ifc.round_count_disp !== 2'd2) begin
          n_err++; $display("FAIL out_of_lives got a%0d b%0d r%0d exp a0 b2 r2", ifc.scoreA_disp, ifc.scoreB_disp, ifc.round_count_disp);
        end
      end
    end
    idle(8);
    n_vec++; if (ifc.led_feedback !== 8'h0F) begin n_err++; $display("FAIL finish_b_wins got %h exp 0F", ifc.led_feedback); end
    press(1'b0, 3'd2);
    press(1'b1, 3'd2);
    idle(20);
    n_vec++; if (ifc.led_feedback !== 8'h0F || ifc.leds_debug !== 12'hFFF) begin
      n_err++; $display("FAIL finish_hold got %h %h exp 0F FFF", ifc.led_feedback, ifc.leds_debug);
    end
  endtask

  task automatic test_partial_and_reset;
    logic [3:0][2:0] sec;
    sec = mk(3'd1, 3'd2, 3'd3, 3'd4);
    @(negedge clk); rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    ifc.SW = 3'd0; ifc.enterA = 1'b1; ifc.enterB = 1'b1;
    @(negedge clk);
    ifc.enterA = 1'b0; ifc.enterB = 1'b0;
    press(1'b0, 3'd0);
    press(1'b1, 3'd5);
    n_vec++; if (ifc.leds_debug !== 12'h000) begin n_err++; $display("FAIL tie_ignored got %h exp 000", ifc.leds_debug); end
    press(1'b0, 3'd1);
    n_vec++; if (ifc.leds_debug !== 12'h200) begin n_err++; $display("FAIL tie_a_maker got %h exp 200", ifc.leds_debug); end
    for (int k = 1; k < 4; k++) press(1'b0, sec[k]);
    n_vec++; if (ifc.leds_debug !== 12'h29C) begin n_err++; $display("FAIL secret_29C got %h exp 29C", ifc.leds_debug); end
    idle(4);
    guess(1'b1, mk(3'd2, 3'd1, 3'd3, 3'd7), 8'b01_01_11_00);
    exp_fb = exp_fb_q.pop_front();
    n_vec++; if (ifc.led_feedback !== exp_fb) begin n_err++; $display("FAIL fb_partial got %h exp %h", ifc.led_feedback, exp_fb); end
    idle(4);
    n_vec++; if (ifc.led_feedback !== 8'h03) begin n_err++; $display("FAIL lives_2 got %h exp 03", ifc.led_feedback); end
    idle(4);
    guess(1'b1, mk(3'd4, 3'd4, 3'd3, 3'd1), model_fb(sec, mk(3'd4, 3'd4, 3'd3, 3'd1)));
    exp_fb = exp_fb_q.pop_front();
    n_vec++; if (ifc.led_feedback !== exp_fb) begin n_err++; $display("FAIL fb_dup got %h exp %h", ifc.led_feedback, exp_fb); end
    idle(4);
    n_vec++; if (ifc.led_feedback !== 8'h01) begin n_err++; $display("FAIL lives_1 got %h exp 01", ifc.led_feedback); end
    idle(4);
    press(1'b1, 3'd1);
    press(1'b1, 3'd2);
    rst_n = 1'b0;
    #1;
    n_vec++; if ({ifc.round_count_disp, ifc.scoreA_disp, ifc.scoreB_disp, ifc.leds_debug, ifc.led_feedback} !== 26'd0) begin
      n_err++; $display("FAIL mid_reset got %h %h exp all zero", ifc.leds_debug, ifc.led_feedback);
    end
    idle(2);
    rst_n = 1'b1;
    press(1'b1, 3'd0);
    press(1'b0, 3'd3);
    press(1'b1, 3'd5);
    n_vec++; if (ifc.leds_debug !== 12'hA00) begin n_err++; $display("FAIL fresh_game got %h exp A00", ifc.leds_debug); end
  endtask

  initial begin
    test_reset();
    test_round_b_wins();
    test_b_maker_to_finish();
    test_partial_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
